// File: rtl/id_ex_stage_pkg.sv
// Shared control-field encodings and opcode lookups for the decode/execute boundary.
package id_ex_stage_pkg;

  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned ALUOP_W    = 2;
  localparam int unsigned EX_CTRL_W  = 4;
  localparam int unsigned MEM_CTRL_W = 2;
  localparam int unsigned WB_CTRL_W  = 1;

  localparam logic [ALUOP_W-1:0] ALUOP_MEM    = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_IMM    = 2'b11;

  localparam int unsigned MEM_CS_BIT = 1;
  localparam int unsigned MEM_WE_BIT = 0;

  localparam logic [MEM_CTRL_W-1:0] MEM_CTRL_NOP   = 2'b00;
  localparam logic [MEM_CTRL_W-1:0] MEM_CTRL_LOAD  = 2'b10;
  localparam logic [MEM_CTRL_W-1:0] MEM_CTRL_STORE = 2'b11;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0d;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2b;

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               reg_dst;
  } ex_ctrl_t;

  typedef struct packed {
    logic cs;
    logic we;
  } mem_ctrl_t;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    logic      wb;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // ALUop issued by the main decoder for each opcode class
  function automatic logic [ALUOP_W-1:0] alu_op_for(input logic [OPCODE_W-1:0] opcode);
    logic [ALUOP_W-1:0] op;
    op = ALUOP_MEM;
    case (opcode)
      OP_RTYPE:      op = ALUOP_FUNCT;
      OP_BEQ:        op = ALUOP_BRANCH;
      OP_ORI:        op = ALUOP_IMM;
      OP_LW, OP_SW:  op = ALUOP_MEM;
      default:       op = ALUOP_MEM;
    endcase
    return op;
  endfunction

  function automatic logic is_load(input logic [MEM_CTRL_W-1:0] mem_ctrl);
    return mem_ctrl[MEM_CS_BIT] & ~mem_ctrl[MEM_WE_BIT];
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detector.sv
// Combinational load-use hazard: a load in EX whose destination is read by the ID instruction.
module load_use_detector
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic                  ex_valid,
  input  logic [MEM_CTRL_W-1:0] ex_mem_ctrl,
  input  logic [REG_AW-1:0]     ex_rt,
  input  logic                  id_valid,
  input  logic [REG_AW-1:0]     id_rs,
  input  logic [REG_AW-1:0]     id_rt,
  output logic                  hazard
);

  logic ex_is_load;
  logic rt_match;

  assign ex_is_load = ex_valid & is_load(ex_mem_ctrl);
  // $zero is never a real producer, so it cannot create a dependency
  assign rt_match   = (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
  assign hazard     = ex_is_load & id_valid & rt_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash and a saturating bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [EX_CTRL_W-1:0]  EX_ctrl_i,
  input  logic [MEM_CTRL_W-1:0] MEM_ctrl_i,
  input  logic [WB_CTRL_W-1:0]  WB_ctrl_i,
  input  logic [DATA_W-1:0]     rs_data_i,
  input  logic [DATA_W-1:0]     rt_data_i,
  input  logic [DATA_W-1:0]     imm_i,
  input  logic [REG_AW-1:0]     rs_i,
  input  logic [REG_AW-1:0]     rt_i,
  input  logic [REG_AW-1:0]     rd_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  valid_o,
  output logic [EX_CTRL_W-1:0]  EX_ctrl_o,
  output logic [MEM_CTRL_W-1:0] MEM_ctrl_o,
  output logic [WB_CTRL_W-1:0]  WB_ctrl_o,
  output logic [DATA_W-1:0]     rs_data_o,
  output logic [DATA_W-1:0]     rt_data_o,
  output logic [DATA_W-1:0]     imm_o,
  output logic [REG_AW-1:0]     rs_o,
  output logic [REG_AW-1:0]     rt_o,
  output logic [REG_AW-1:0]     rd_o,
  output logic [CNT_W-1:0]      bubble_cnt_o
);

  logic  hazard;
  logic  bubble;
  logic  cnt_en;
  ctrl_t ctrl_in;
  ctrl_t ctrl_q;

  load_use_detector #(.REG_AW(REG_AW)) u_detector (
    .ex_valid    (valid_o),
    .ex_mem_ctrl (MEM_ctrl_o),
    .ex_rt       (rt_o),
    .id_valid    (valid_i),
    .id_rs       (rs_i),
    .id_rt       (rt_i),
    .hazard      (hazard)
  );

  // A flush squashes the ID instruction anyway, so it never needs to be held
  assign stall_o = hazard & ~flush_i;
  assign bubble  = stall_o | flush_i;
  assign cnt_en  = bubble & (valid_i | flush_i);
  assign ctrl_in = valid_i ? ctrl_t'({EX_ctrl_i, MEM_ctrl_i, WB_ctrl_i}) : CTRL_NOP;

  assign EX_ctrl_o  = ctrl_q.ex;
  assign MEM_ctrl_o = ctrl_q.mem;
  assign WB_ctrl_o  = ctrl_q.wb;

  // Pipeline register: bubble loads all-zero, otherwise capture ID
  always_ff @(posedge clk_i) begin
    if (rst_i || bubble) begin
      valid_o   <= 1'b0;
      ctrl_q    <= CTRL_NOP;
      rs_data_o <= '0;
      rt_data_o <= '0;
      imm_o     <= '0;
      rs_o      <= '0;
      rt_o      <= '0;
      rd_o      <= '0;
    end else begin
      valid_o   <= valid_i;
      ctrl_q    <= ctrl_in;
      rs_data_o <= rs_data_i;
      rt_data_o <= rt_data_i;
      imm_o     <= imm_i;
      rs_o      <= rs_i;
      rt_o      <= rt_i;
      rd_o      <= rd_i;
    end
  end

  // Saturating bubble counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_o <= '0;
    end else if (cnt_en && !(&bubble_cnt_o)) begin
      bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register with integrated load-use hazard detection. It sits directly downstream of the general control decoder and the register file read. It latches the decoded EX/MEM/WB control words, operands and register addresses into the EX stage. It inserts a one-cycle bubble on a load-use hazard, back-pressures IF/ID via stall_o, and squashes on branch/jump flush.

Parameters:
DATA_W, 32, operand/immediate width
REG_AW, 5, register address width
CNT_W, 16, bubble counter width

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
valid_i  in  1  ID holds a real instruction
EX_ctrl_i  in  4  {ALUop[1:0], ALUsrc, RegDst} from control decoder
MEM_ctrl_i  in  2  {MEM_cs, MEM_we}
WB_ctrl_i  in  1  writeback select (0: memory, 1: ALU)
rs_data_i  in  DATA_W  register file port A
rt_data_i  in  DATA_W  register file port B
imm_i  in  DATA_W  sign-extended immediate
rs_i, rt_i, rd_i  in  REG_AW each  ID register addresses
flush_i  in  1  branch taken / jump: squash ID instruction
stall_o  out  1  hold PC and IF/ID this cycle (combinational)
valid_o  out  1  EX holds a real instruction
EX_ctrl_o  out  4  registered
MEM_ctrl_o  out  2  registered
WB_ctrl_o  out  1  registered
rs_data_o, rt_data_o, imm_o  out  DATA_W  registered
rs_o, rt_o, rd_o  out  REG_AW  registered
bubble_cnt_o  out  CNT_W  bubbles inserted since reset, saturating

Behaviour:
- Reset (rst_i high at edge): every registered output, including bubble_cnt_o, is 0. valid_o=0. Reset wins over all other inputs, including mid-stall and mid-flush.
- Latency: 1 cycle from ID inputs to outputs when no bubble is inserted.
- Load in EX: valid_o & MEM_ctrl_o==2'b10 (cs=1, we=0).
- hazard = load in EX & valid_i & rt_o!=0 & (rt_o==rs_i | rt_o==rt_i).
- stall_o = hazard & ~flush_i. This is purely combinational from the current EX registers and ID inputs.
- Bubble: on an edge where stall_o or flush_i is 1, the register captures all-zero control, valid_o=0, and zero data/addresses. EX_ctrl 0 / MEM_ctrl 0 means no memory access. A bubble carries no writeback effect downstream: valid_o=0 gates it.
- Normal capture: otherwise the register captures all ID inputs, with valid_o=valid_i. If valid_i=0, control is forced to 0.
- Stall length is exactly one cycle. After the bubble, EX holds valid_o=0, so hazard falls. The held ID instruction is captured on the next edge.
- Back-to-back loads with a dependency each stall exactly once.
- Flush and hazard in the same cycle: flush wins. stall_o=0, one bubble, counted once.
- bubble_cnt_o increments by 1 on every bubble edge (stall or flush), except when valid_i=0 and flush_i=0. It saturates at 2^CNT_W-1 with no wrap.
- rt_o==0 never causes a hazard. $zero loads are harmless.
- Store in EX (MEM_ctrl 2'b11) never causes a hazard.

Decomposition:
- Shared header: opcode and control-field constants (ALUop encodings, MEM_ctrl bit indices, LOAD/STORE MEM_ctrl values, all-zero NOP control word), alongside existing ALU/opcode lookups.
- One sub-module: load_use_detector (combinational hazard term). The pipeline register, bubble mux and counter stay in id_ex_stage.

Test Plan:
1. Reset: drive valid_i=1, EX_ctrl_i=4'b1011, rst_i=1 for 2 cycles -> all outputs 0, valid_o=0, bubble_cnt_o=0.
2. Pass-through: ADD, rs_data_i=0x5, rt_data_i=0x7, rd_i=3 -> next cycle EX_ctrl_o={ADD_alu,0,1}, rs_data_o=0x5, rt_data_o=0x7, rd_o=3, valid_o=1, stall_o=0.
3. Load-use: LW with rt=8 captured, then ID presents ADD with rs=8 -> stall_o=1 that cycle; next cycle valid_o=0 with zero control, bubble_cnt_o=1; following cycle ADD captured, stall_o=0.
4. No false hazard: LW with rt=0 followed by ADD with rs=0 -> stall_o=0. SW with rt=8 followed by ADD with rs=8 -> stall_o=0.
5. Flush overrides hazard: LW with rt=4 in EX, ID has rs=4, flush_i=1 -> stall_o=0, bubble next cycle, counter +1 only.
6. Saturation (CNT_W=2): 5 consecutive flushes with valid_i=1 -> bubble_cnt_o sequence 1,2,3,3,3. Assert rst_i mid-stall -> counter and outputs 0 next cycle.
